// File: rtl/bcd_conv_sched_if.sv
// Request/response bus for the shared binary-to-BCD converter.
//   req_valid/req_data/req_ready : per-requester offer of a 16-bit operand,
//                                  requester i owns req_data[16*i+15:16*i]
//   rsp_valid/rsp_ready          : result handshake
//   rsp_id                       : index of the requester that owns rsp_bcd
//   rsp_bcd                      : five packed BCD digits, units in [3:0]
// master = requesters + result consumer, slave = the converter.
interface bcd_conv_sched_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [19:0]          rsp_bcd;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_bcd
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_bcd
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared sequential binary-to-BCD converter with a round-robin front end.
// One requester is granted per IDLE cycle; its 16-bit operand is converted
// by double-dabble at one shift per clock (16 steps), and the five-digit
// result is returned tagged with the requester index.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bus (slave side), see bcd_conv_sched_if
//   busy  : high whenever a conversion or an unconsumed result is in flight
module bcd_conv_sched #(
  parameter int unsigned NREQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_conv_sched_if.slave  bus,
  output logic             busy
);
  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [35:0]    sr_q, sr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [19:0]    rsp_bcd_q, rsp_bcd_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [15:0]    operand;
  logic [35:0]    sr_step;
  logic [NREQ-1:0] req_ready_c;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Only the granted lane is sampled, so X on idle lanes never reaches state.
  assign operand = bus.req_data[16*grant_idx +: 16];

  // One double-dabble step: correct the four lower digit fields, then shift.
  // The top field never needs correction because 65535 < 70000.
  always_comb begin
    sr_step = sr_q;
    for (int d = 0; d < 4; d++) begin
      if (sr_q[16+4*d +: 4] >= 4'd5) begin
        sr_step[16+4*d +: 4] = sr_q[16+4*d +: 4] + 4'd3;
      end
    end
    sr_step = {sr_step[34:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_bcd_d   = rsp_bcd_q;
    req_ready_c = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          sr_d     = {20'b0, operand};
          rsp_id_d = grant_idx;
          ptr_d    = grant_idx;
          cnt_d    = 4'd0;
          state_d  = StConv;
        end
      end
      StConv: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          rsp_bcd_d   = sr_step[35:16];
          rsp_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IDW'(NREQ - 1);
      sr_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_bcd_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_bcd_q   <= rsp_bcd_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_bcd   = rsp_bcd_q;
  assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  bcd_conv_sched_if #(.NREQ(NREQ)) bus ();

  bcd_conv_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input logic [15:0] d);
    bus.req_valid[id] = v;
    bus.req_data[16*id +: 16] = d;
  endtask

  // Bounded wait for any grant, then check it is the expected one-hot.
  task automatic wait_grant(input int exp_id, input string tag);
    int n;
    n = 0;
    while (bus.req_ready == '0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << exp_id));
  endtask

  // Called right after the accept edge; checks latency and result.
  task automatic wait_rsp(input int exp_id, input int unsigned v, input string tag);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd16);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({tag, "_bcd"}, 32'(bus.rsp_bcd), 32'(ref_bcd(v)));
  endtask

  // Full single transaction with rsp_ready held high.
  task automatic xact(input int id, input int unsigned v, input string tag);
    set_req(id, 1'b1, 16'(v));
    #1;
    wait_grant(id, tag);
    tick();
    chk({tag, "_rdy_low"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    set_req(id, 1'b0, 16'(v));
    wait_rsp(id, v, tag);
    tick();
    chk({tag, "_rsp_clr"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int unsigned vals[5];
    int unsigned v;
    int id;
    int acc;
    int last_acc;
    int exp_id;
    int bad;
    int seen;

    bus.req_valid = '0;
    bus.req_data  = 'x;
    bus.rsp_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Single max-value request.
    xact(0, 65535, "max");

    // Boundary operands.
    vals = '{0, 9, 10, 9999, 10000};
    foreach (vals[i]) xact(0, vals[i], "bound");

    // Random single requests.
    for (int i = 0; i < 8; i++) begin
      id = int'($urandom_range(0, NREQ - 1));
      v  = $urandom_range(0, 65535);
      xact(id, v, "rand");
    end

    // Four simultaneous requests from reset: id order, 18-cycle spacing.
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    vals[0] = 1; vals[1] = 22; vals[2] = 333; vals[3] = 4444;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 16'(vals[k]));
    #1;
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(k, "sim");
      tick();
      acc = cyc;
      if (k > 0) chk("sim_spacing", 32'(acc - last_acc), 32'd18);
      last_acc = acc;
      set_req(k, 1'b0, 16'(vals[k]));
      wait_rsp(k, vals[k], "sim");
      tick();
    end

    // Fairness: req0 and req2 held valid continuously.
    set_req(0, 1'b1, 16'd12345);
    set_req(2, 1'b1, 16'd54321);
    #1;
    exp_id = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(exp_id, "fair");
      tick();
      wait_rsp(exp_id, (exp_id == 0) ? 12345 : 54321, "fair");
      tick();
      exp_id = (exp_id == 0) ? 2 : 0;
    end
    set_req(0, 1'b0, 16'd0);
    set_req(2, 1'b0, 16'd0);

    // Backpressure with req1 waiting.
    bus.rsp_ready = 1'b0;
    v = $urandom_range(0, 65535);
    set_req(0, 1'b1, 16'd31415);
    #1;
    wait_grant(0, "bp");
    tick();
    set_req(0, 1'b0, 16'd31415);
    set_req(1, 1'b1, 16'(v));
    wait_rsp(0, 31415, "bp");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 ||
          bus.rsp_bcd !== 20'h31415 || bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
      end
    end
    chk("bp_stable_bad_cycles", 32'(bad), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_clr", 32'(bus.rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 16'(v));
    wait_rsp(1, v, "bp_req1");
    tick();

    // Reset mid-conversion.
    set_req(2, 1'b1, 16'd4321);
    #1;
    wait_grant(2, "mid");
    tick();
    set_req(2, 1'b0, 16'd4321);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("mid_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
    chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    xact(3, 7, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
Shared binary-to-BCD conversion engine with a round-robin scheduler in front of it. NREQ requesters each offer a 16-bit binary value over a valid/ready handshake. The block grants one requester at a time and runs a sequential double-dabble conversion at one shift per clock. It returns five BCD digits tagged with the requester index. It replaces per-consumer combinational converters where display and telemetry paths need BCD at low rate.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester index (derived, not overridden)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_data  in  16*NREQ  binary operand; requester i uses bits [16*i+15:16*i]
req_ready  out  NREQ  grant/accept strobe, at most one bit high
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of requester that owns rsp_bcd
rsp_bcd  out  20  {BCD4,BCD3,BCD2,BCD1,BCD0}, 4 bits per digit, BCD0 = units
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_id=0, rsp_bcd=0, req_ready=0, busy=0, rr pointer=NREQ-1 so requester 0 has first priority, counter=0, shift reg=0.
- FSM states: IDLE, CONV, DONE.
- IDLE: search order last+1, last+2, ... wrapping mod NREQ. The first i with req_valid[i]=1 wins. req_ready[i] is driven combinationally high in that cycle only. Accept edge = the clock edge where req_valid&req_ready. At that edge: shift reg (36b) <= {20'b0, operand}; rsp_id <= i; pointer <= i; counter <= 0; state -> CONV. No valid requests: stay in IDLE, req_ready=0.
- req_ready is 0 in CONV and DONE. Requesters hold req_valid/req_data stable until accepted. Deasserting before acceptance is allowed; that requester is not granted.
- CONV: on each edge, apply one double-dabble step to the registered shift reg:
  - add 3 to each of digit fields [19:16], [23:20], [27:24], [31:28] that are >=5 (each field 4-bit, add once);
  - then shift the whole 36-bit reg left by 1.
  - counter increments. The edge performing step 16 (counter==15) writes rsp_bcd <= result[35:16] of that step and sets rsp_valid=1; state -> DONE.
- Latency: rsp_valid is high in the 16th cycle after the accept edge (accept edge E0, steps on E1..E16, rsp_valid visible after E16).
- DONE: rsp_valid=1. rsp_id and rsp_bcd are held stable. On an edge with rsp_ready=1: rsp_valid <= 0, state -> IDLE. Backpressure is unbounded.
- rsp_bcd and rsp_id hold their last values after handshake until the next completion. Consumers qualify them with rsp_valid only.
- Minimum request-to-request spacing: 18 cycles (accept, 16 steps, IDLE arbitration cycle after rsp handshake).
- Range: operand 0..65535. BCD4 never exceeds 6 and every digit is <=9.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously requesting requester cannot starve another, because the pointer advances past each winner.
- Reset mid-CONV or mid-DONE: conversion and pending result are discarded, all outputs return to reset values, and the pointer returns to NREQ-1.
- X on req_data of non-granted requesters must not propagate into state.

Test Plan:
- Single request, NREQ=4: req0 data=16'hFFFF, rsp_ready=1. Expected: req_ready[0] high one cycle; rsp_valid high 16 cycles after accept edge; rsp_bcd=20'h65535; rsp_id=0; busy low again the cycle after the response handshake.
- Zero and boundaries: data=0 -> 20'h00000; 9 -> 20'h00009; 10 -> 20'h00010; 9999 -> 20'h09999; 10000 -> 20'h10000. All rsp_id=0.
- Four simultaneous requests from reset, data 1, 22, 333, 4444 on req0..3. Expected: grants and responses in id order 0, 1, 2, 3 with rsp_bcd 0x00001, 0x00022, 0x00333, 0x04444; accept edges exactly 18 cycles apart.
- Fairness: req0 and req2 held valid continuously (data 12345 and 54321). Expected: responses alternate ids 0, 2, 0, 2 with rsp_bcd 0x12345 / 0x54321; neither requester is granted twice in a row.
- Backpressure: rsp_ready=0 for 50 cycles after rsp_valid for data=31415. Expected: rsp_valid, rsp_id and rsp_bcd=0x31415 stable throughout; req_ready stays 0 for a waiting req1; req1 is granted in the first IDLE cycle after rsp_ready=1.
- Reset mid-conversion: pulse rst_n low asynchronously 8 cycles after accepting 4321. Expected: outputs at reset values immediately, no response emitted for 4321; after release, req3 alone data=7 -> rsp_bcd 0x00007, rsp_id 3.
